// File: rtl/aes32_col_iter.sv
// Multi-cycle RV32 AES byte/column unit: single-byte (Inv)SubBytes(+MixColumn) ops
// plus a column mode that folds all four bytes of rs2 through NSBOX shared S-boxes.

module aes_sbox (
  input  logic [7:0] in_byte,
  input  logic       inv,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotb(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ rotb(x, 1) ^ rotb(x, 2) ^ rotb(x, 3) ^ rotb(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return rotb(x, 1) ^ rotb(x, 3) ^ rotb(x, 6) ^ 8'h05;
  endfunction

  logic [7:0] pre;
  logic [7:0] g;

  always_comb begin
    pre      = inv ? inv_affine(in_byte) : in_byte;
    g        = gf_inv(pre);
    out_byte = inv ? g : affine(g);
  end

endmodule

module aes32_col_iter #(
  parameter int NSBOX    = 1,
  parameter int GATE_OUT = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        op_encs,
  input  logic        op_encsm,
  input  logic        op_decs,
  input  logic        op_decsm,
  input  logic        col,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [1:0]  bs,
  input  logic        flush,
  output logic [31:0] rd,
  output logic        ready,
  output logic        busy
);

  localparam int ITER  = 4 / NSBOX;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        acc;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        rs2_q;
  logic [1:0]         bs_q;
  logic               col_q;
  logic               dec_q;
  logic               mix_q;
  logic               any_q;
  logic               last;
  logic               accept;
  logic [31:0]        lane_xor;
  logic [31:0]        contrib [NSBOX];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Column word for one S-box output, rotated into the row of its source byte.
  function automatic logic [31:0] lane_word(input logic [7:0] s, input logic [1:0] k,
                                            input logic dec, input logic mix);
    logic [7:0]  m2, m4, m8;
    logic [31:0] w;
    m2 = xt(s);
    m4 = xt(m2);
    m8 = xt(m4);
    if (!mix)     w = {24'h0, s};
    else if (dec) w = {m8 ^ m2 ^ s, m8 ^ m4 ^ s, m8 ^ s, m8 ^ m4 ^ m2};
    else          w = {m2 ^ s, s, s, m2};
    case (k)
      2'd0:    return w;
      2'd1:    return {w[23:0], w[31:24]};
      2'd2:    return {w[15:0], w[31:16]};
      default: return {w[7:0],  w[31:8]};
    endcase
  endfunction

  for (genvar j = 0; j < NSBOX; j++) begin : g_lane
    logic [1:0]  idx;
    logic [7:0]  sx;
    logic [7:0]  sy;
    logic        en;

    assign idx = col_q ? 2'(int'(cnt) * NSBOX + j) : bs_q;
    assign sx  = rs2_q[8*idx +: 8];
    assign en  = any_q & (col_q | (j == 0));

    aes_sbox u_sbox (
      .in_byte  (sx),
      .inv      (dec_q),
      .out_byte (sy)
    );

    assign contrib[j] = en ? lane_word(sy, idx, dec_q, mix_q) : 32'h0;
  end

  always_comb begin
    lane_xor = '0;
    for (int j = 0; j < NSBOX; j++) lane_xor = lane_xor ^ contrib[j];
  end

  assign last   = (cnt == CNT_W'(ITER - 1));
  assign accept = (state_q == IDLE) & valid & ~flush;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY: begin
        if (flush)                state_d = IDLE;
        else if (!col_q || last)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch and accumulator; priority decsm > decs > encsm > encs folds into dec/mix.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      acc   <= '0;
      cnt   <= '0;
      rs2_q <= '0;
      bs_q  <= '0;
      col_q <= 1'b0;
      dec_q <= 1'b0;
      mix_q <= 1'b0;
      any_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc   <= rs1;
            cnt   <= '0;
            rs2_q <= rs2;
            bs_q  <= bs;
            col_q <= col;
            dec_q <= op_decs | op_decsm;
            mix_q <= op_decsm | (~op_decs & op_encsm);
            any_q <= op_encs | op_encsm | op_decs | op_decsm;
          end
        end
        BUSY: begin
          if (flush) begin
            acc <= '0;
          end else begin
            acc <= acc ^ lane_xor;
            if (col_q && !last) cnt <= cnt + 1'b1;
          end
        end
        DONE:    if (flush) acc <= '0;
        default: acc <= acc;
      endcase
    end
  end

  assign ready = (state_q == DONE) & ~flush;
  assign busy  = (state_q != IDLE);
  assign rd    = ((GATE_OUT != 0) && !ready) ? 32'h0 : acc;

endmodule

// File: tb/tb_aes32_col_iter.sv
// Scoreboard bench for aes32_col_iter: directed vectors, flush/reset aborts,
// back-to-back handshake and randomized requests against a table-driven AES model.

module tb_aes32_col_iter;

  localparam int NSBOX = 1;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        valid = 1'b0;
  logic        op_encs = 1'b0, op_encsm = 1'b0, op_decs = 1'b0, op_decsm = 1'b0;
  logic        col = 1'b0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [1:0]  bs = '0;
  logic        flush = 1'b0;
  logic [31:0] rd;
  logic        ready, busy;

  aes32_col_iter #(.NSBOX(NSBOX), .GATE_OUT(1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid),
    .op_encs(op_encs), .op_encsm(op_encsm), .op_decs(op_decs), .op_decsm(op_decsm),
    .col(col), .rs1(rs1), .rs2(rs2), .bs(bs), .flush(flush),
    .rd(rd), .ready(ready), .busy(busy)
  );

  always #5 g_clk = ~g_clk;

  int cyc = 0;
  always @(posedge g_clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] val; int t; int lat; } exp_t;
  exp_t sb [$];

  logic [7:0] sbox_t [256];
  logic [7:0] isbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int x, y, p;
    x = a; y = b; p = 0;
    while (y != 0) begin
      if (y % 2 == 1) p = p ^ x;
      x = x * 2;
      if (x >= 256) x = x ^ 'h11b;
      y = y / 2;
    end
    return 8'(p);
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv, b;
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
      sbox_t[x] = b;
    end
    for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
  endtask

  // ops = {decsm, decs, encsm, encs}
  function automatic logic [31:0] model(input logic [3:0] ops, input logic c,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] s);
    logic dec, mix;
    logic [31:0] r, w;
    logic [7:0] x, sv;
    int lo, hi;
    if (ops[3])      begin dec = 1; mix = 1; end
    else if (ops[2]) begin dec = 1; mix = 0; end
    else if (ops[1]) begin dec = 0; mix = 1; end
    else             begin dec = 0; mix = 0; end
    r = a;
    if (ops == 4'b0000) return r;
    lo = c ? 0 : int'(s);
    hi = c ? 3 : int'(s);
    for (int k = lo; k <= hi; k++) begin
      x  = b[8*k +: 8];
      sv = dec ? isbox_t[x] : sbox_t[x];
      if (!mix)     w = {24'h0, sv};
      else if (dec) w = {gmul(sv, 8'd11), gmul(sv, 8'd13), gmul(sv, 8'd9), gmul(sv, 8'd14)};
      else          w = {gmul(sv, 8'd3), sv, sv, gmul(sv, 8'd2)};
      if (k != 0) w = (w << (8*k)) | (w >> (32 - 8*k));
      r = r ^ w;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exv);
    end
  endtask

  task automatic set_ops(input logic [3:0] ops, input logic c, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] s);
    {op_decsm, op_decs, op_encsm, op_encs} = ops;
    col = c; rs1 = a; rs2 = b; bs = s;
  endtask

  function automatic int lat_of(input logic c);
    return c ? 1 + 4 / NSBOX : 2;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge g_clk); #1;
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
    end
  endtask

  task automatic issue(input logic [3:0] ops, input logic c, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] s, input logic [31:0] exv);
    exp_t e;
    @(posedge g_clk); #1;
    set_ops(ops, c, a, b, s);
    valid = 1'b1;
    e.val = exv; e.t = cyc; e.lat = lat_of(c);
    sb.push_back(e);
    @(posedge g_clk); #1;
    valid = 1'b0;
    set_ops(4'h0, 1'b0, $urandom, $urandom, 2'(s + 1));
    wait_idle();
  endtask

  // Monitor: compares every ready pulse with the oldest expectation.
  always @(negedge g_clk) begin
    exp_t e;
    if (g_resetn) begin
      if (ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: rd %h with no request pending", rd);
        end else begin
          e = sb.pop_front();
          checks++;
          if (rd !== e.val) begin
            errors++;
            $display("FAIL rd_value: got %h expected %h", rd, e.val);
          end
          checks++;
          if (cyc - e.t != e.lat) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d", cyc - e.t, e.lat);
          end
        end
      end else if (rd !== 32'h0) begin
        checks++;
        errors++;
        $display("FAIL rd_gated: got %h expected 00000000", rd);
      end
    end
  end

  initial begin
    logic [31:0] ssum;
    int t0, lat;
    exp_t e;
    build_tables();
    chk("model_sbox0", {24'h0, sbox_t[0]}, 32'h63);
    chk("model_isbox0", {24'h0, isbox_t[0]}, 32'h52);

    #12;
    chk("reset_ready", {31'h0, ready}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_rd", rd, 32'h0);
    @(posedge g_clk); #1;
    g_resetn = 1'b1;

    issue(4'b0010, 1'b0, 32'h0, 32'h0, 2'd0, 32'ha56363c6);
    issue(4'b0010, 1'b0, 32'h0, 32'h0, 2'd1, 32'h6363c6a5);
    issue(4'b0100, 1'b0, 32'hffffffff, 32'h0, 2'd2, 32'hffadffff);
    issue(4'b0001, 1'b1, 32'h0, 32'h0, 2'd0, 32'h63636363);
    issue(4'b0010, 1'b1, 32'h0, 32'h0, 2'd0, 32'h63636363);
    issue(4'b1000, 1'b1, 32'h0, 32'h0, 2'd0, 32'h52525252);
    issue(4'b0000, 1'b1, 32'h12345678, 32'hdeadbeef, 2'd0, 32'h12345678);

    ssum = 32'h0;
    for (int k = 0; k < 4; k++) begin
      ssum = ssum ^ model(4'b0010, 1'b0, 32'h0, 32'hd4bf5d30, 2'(k));
      issue(4'b0010, 1'b0, 32'h0, 32'hd4bf5d30, 2'(k), model(4'b0010, 1'b0, 32'h0, 32'hd4bf5d30, 2'(k)));
    end
    issue(4'b0010, 1'b1, 32'h0, 32'hd4bf5d30, 2'd0, ssum);

    // Flush on the second BUSY cycle of a column request.
    @(posedge g_clk); #1;
    set_ops(4'b0010, 1'b1, 32'h1, 32'hd4bf5d30, 2'd0);
    valid = 1'b1;
    @(posedge g_clk); #1;
    valid = 1'b0;
    @(posedge g_clk); #1;
    flush = 1'b1;
    @(posedge g_clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'h0, busy}, 32'h0);
    chk("flush_rd", rd, 32'h0);

    // Flush wins over valid in IDLE.
    valid = 1'b1; flush = 1'b1;
    @(posedge g_clk); #1;
    valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", {31'h0, busy}, 32'h0);

    // Reset in the middle of a column request.
    @(posedge g_clk); #1;
    set_ops(4'b1000, 1'b1, 32'hcafef00d, 32'h01020304, 2'd0);
    valid = 1'b1;
    @(posedge g_clk); #1;
    valid = 1'b0;
    #2 g_resetn = 1'b0;
    #1;
    chk("rst_mid_ready", {31'h0, ready}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_rd", rd, 32'h0);
    repeat (3) @(posedge g_clk);
    #1 g_resetn = 1'b1;
    issue(4'b0010, 1'b1, 32'h0, 32'hd4bf5d30, 2'd0, ssum);

    // Back-to-back: A held, operands scrambled while busy, B presented in DONE.
    lat = lat_of(1'b1);
    @(posedge g_clk); #1;
    set_ops(4'b1000, 1'b1, 32'h0f0f0f0f, 32'h11223344, 2'd0);
    valid = 1'b1;
    t0 = cyc;
    e.val = model(4'b1000, 1'b1, 32'h0f0f0f0f, 32'h11223344, 2'd0); e.t = t0; e.lat = lat;
    sb.push_back(e);
    for (int k = 1; k <= lat; k++) begin
      @(posedge g_clk); #1;
      if (k < lat) set_ops(4'($urandom), 1'($urandom), $urandom, $urandom, 2'($urandom));
      else         set_ops(4'b0100, 1'b0, 32'h89abcdef, 32'h55aa33cc, 2'd3);
    end
    @(posedge g_clk); #1;
    e.val = model(4'b0100, 1'b0, 32'h89abcdef, 32'h55aa33cc, 2'd3); e.t = t0 + lat + 1; e.lat = 2;
    sb.push_back(e);
    chk("b2b_accept_busy", {31'h0, busy}, 32'h0);
    @(posedge g_clk); #1;
    valid = 1'b0;
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      logic [3:0] ops;
      logic c;
      logic [31:0] a, b;
      logic [1:0] s;
      ops = 4'($urandom_range(0, 15));
      c   = 1'($urandom);
      a   = $urandom;
      b   = $urandom;
      s   = 2'($urandom);
      issue(ops, c, a, b, s, model(ops, c, a, b, s));
    end

    repeat (5) @(posedge g_clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes32_col_iter.md
Name: aes32_col_iter

Overview:
- Multi-cycle, parametrised successor to the single-cycle RV32 AES byte unit.
- Keeps the four byte-select ops: encs, encsm, decs, decsm.
- Adds a column mode that processes all four bytes of rs2 in one request. It iterates over NSBOX shared S-box instances and accumulates the T-table sum, which yields rs1 ^ (Inv)MixColumns((Inv)SubBytes(rs2)).
- Sits in the core's crypto functional unit behind the valid/ready handshake.

Parameters:
- NSBOX, 1, number of S-box instances (legal values 1, 2, 4); sets column-mode iteration count to 4/NSBOX.
- GATE_OUT, 1, when 1, rd is forced to 0 whenever ready is 0; when 0, rd shows the accumulator at all times.

Ports:
- g_clk  input  1  clock, rising edge.
- g_resetn  input  1  asynchronous active-low reset.
- valid  input  1  request valid; held high with stable operands until ready.
- op_encs  input  1  encrypt SubBytes.
- op_encsm  input  1  encrypt SubBytes + MixColumn.
- op_decs  input  1  decrypt SubBytes.
- op_decsm  input  1  decrypt SubBytes + InvMixColumn.
- col  input  1  1 = full-column mode (bs ignored); 0 = single-byte mode.
- rs1  input  32  source register 1 (XOR addend).
- rs2  input  32  source register 2 (byte source).
- bs  input  2  byte select, single-byte mode only.
- flush  input  1  synchronous abort of any in-flight operation.
- rd  output  32  result, valid while ready=1.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high in BUSY and DONE states.

Behaviour:
- Reset (g_resetn=0, async):
  - State goes to IDLE; acc, counter and latched operands go to 0.
  - ready=0, busy=0, rd=0.
  - Reset mid-operation discards the operation; no ready is produced for it.
- Op decode:
  - dec = op_decs|op_decsm; mix = op_encsm|op_decsm.
  - Multiple ops asserted: priority decsm > decs > encsm > encs.
  - No op asserted: request still completes, with per-byte contribution 0, so rd = rs1.
- Per-byte function f(x, k), rotated left by 8*k:
  - s = sbox(x) when enc, inv_sbox(x) when dec.
  - mix=0: word {24'b0, s}.
  - mix=1, enc: {3s, s, s, 2s}.
  - mix=1, dec: {11s, 13s, 9s, 14s}.
  - GF(2^8) multiply is modulo 0x11b.
- FSM IDLE -> BUSY -> DONE -> IDLE.
  - IDLE: if valid, latch rs1, rs2, bs, col and decoded op; set acc=rs1, cnt=0; go to BUSY.
  - BUSY, single-byte mode: one cycle; acc ^= f(rs2 byte bs, bs); go to DONE.
  - BUSY, column mode: 4/NSBOX cycles. In each cycle, lanes j=0..NSBOX-1 process byte i = cnt*NSBOX + j and apply acc ^= f(rs2 byte i, i); cnt increments. After the last cycle (cnt = 4/NSBOX-1), go to DONE.
  - DONE: ready=1 and rd=acc for exactly one cycle, then IDLE.
- Latency from valid sampled in IDLE at cycle t:
  - single-byte mode: ready at t+2.
  - column mode: ready at t+1+4/NSBOX.
- Throughput and handshake:
  - At most one request in flight.
  - Operands are sampled once in IDLE; later changes while busy are ignored.
  - valid still high in the IDLE cycle after DONE is taken as a new request, so the requester must drop valid the cycle after ready.
- flush:
  - In BUSY or DONE, the next state is IDLE, no ready is produced, and acc is cleared.
  - In IDLE, flush has priority over valid; the request is not accepted that cycle.
- Counter: width is clog2(4/NSBOX) bits (minimum 1). Wrap-around is never used; cnt resets to 0 on each accept.
- S-box instances: NSBOX copies of the existing aes_sbox (inv = dec). Mix/rotate logic is combinational between the S-box and the acc XOR. acc is the only datapath register besides the operand latches.
- rd:
  - GATE_OUT=1: rd = ready ? acc : 0.
  - GATE_OUT=0: rd = acc.

Test Plan:
- Single-byte, rs1=0, rs2=0x00000000, bs=0, encsm: expect rd=0xa56363c6 two cycles after accept. Repeat with bs=1: expect rd=0x6363c6a5.
- Single-byte, decs, rs2=0, bs=2, rs1=0xffffffff: expect rd=0xffadffff (0x52 XOR'd into byte 2).
- Column mode, rs2=0, rs1=0: encs gives 0x63636363, encsm gives 0x63636363, decsm gives 0x52525252. Ready must arrive at t+5, t+3 and t+2 for NSBOX=1, 2 and 4 respectively.
- Column encsm with rs2=0xd4bf5d30 (FIPS-197 round-1 column, bytes listed b3..b0), rs1=0: result must equal the single-byte encsm sum over bs=0..3 on the same rs2, for every NSBOX.
- Column request, NSBOX=1, with flush pulsed on the 2nd BUSY cycle, then g_resetn pulsed low during a later op: no ready for either op; ready=0, busy=0, rd=0. The next request returns correct results.
- Back-to-back: valid held across ready with new operands presented in the DONE cycle: exactly one ready per accepted op, with each result matching its own operands. Operand changes during BUSY must not affect rd.
